// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core data-memory Wishbone bridge.
package core_mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } bridge_state_e;

    localparam logic [31:0] BUS_FAULT_DATA = 32'hDEAD_BEEF;

    // Unknown funct3 encodings fall into the word case.
    function automatic logic access_aligned(input logic [2:0] op, input logic [1:0] offset);
        case (op)
            MEM_B, MEM_BU: access_aligned = 1'b1;
            MEM_H, MEM_HU: access_aligned = ~offset[0];
            default:       access_aligned = (offset == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store-side sel/data replication and load-side lane
// extraction with sign or zero extension.
module mem_lane_align
    import core_mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  sel,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = rdata_raw >> {offset, 3'b000};
        sel        = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_raw;
        case (op)
            MEM_B: begin
                sel        = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{shifted[7]}}, shifted[7:0]};
            end
            MEM_BU: begin
                sel        = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {24'h0, shifted[7:0]};
            end
            MEM_H: begin
                sel        = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
            end
            MEM_HU: begin
                sel        = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {16'h0, shifted[15:0]};
            end
            default: begin
                sel        = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata_raw;
            end
        endcase
    end

endmodule

// File: rtl/core_wb_master_bridge.sv
// Core memory-stage to Wishbone classic master bridge, one bus cycle per request.
// Optional watchdog abort on a hung slave is enabled with MEM_TIMEOUT_EN.
module core_wb_master_bridge
    import core_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_addr_mem,
    input  logic [31:0]       mem_wdata_mem,
    input  logic              mem_write_mem,
    input  logic              mem_read_mem,
    input  logic [2:0]        mem_op_mem,
    output logic [31:0]       mem_rdata_mem,
    output logic              stall_pipl,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    bridge_state_e state, next_state;

    logic        req;
    logic        aligned;
    logic        start_bus;
    logic        misaligned_req;
    logic        timed_out;
    logic        cyc_q;
    logic [2:0]  op_q;
    logic [1:0]  offset_q;
    logic [2:0]  lane_op;
    logic [1:0]  lane_offset;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign req     = mem_read_mem | mem_write_mem;
    assign aligned = access_aligned(mem_op_mem, mem_addr_mem[1:0]);

    // Lane logic sees the live request in IDLE and the captured one during the bus cycle.
    assign lane_op     = (state == IDLE) ? mem_op_mem : op_q;
    assign lane_offset = (state == IDLE) ? mem_addr_mem[1:0] : offset_q;

    mem_lane_align u_lane (
        .op         (lane_op),
        .offset     (lane_offset),
        .wdata      (mem_wdata_mem),
        .rdata_raw  (wb_dat_i),
        .sel        (lane_sel),
        .wdata_lane (lane_wdata),
        .rdata_ext  (lane_rdata)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int RAW_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 16) ? 16 : RAW_W);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state != BUS)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timed_out = (state == BUS) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state     = state;
        start_bus      = 1'b0;
        misaligned_req = 1'b0;
        case (state)
            IDLE: begin
                if (req && aligned) begin
                    start_bus  = 1'b1;
                    next_state = BUS;
                end else if (req) begin
                    misaligned_req = 1'b1;
                end
            end
            BUS: begin
                if (wb_err_i || wb_ack_i || timed_out)
                    next_state = DONE;
            end
            // The old request is still present here; returning to IDLE keeps it from reissuing.
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign stall_pipl = ~reset & (start_bus | (state == BUS));
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q         <= 1'b0;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            wb_sel_o      <= '0;
            wb_we_o       <= 1'b0;
            op_q          <= '0;
            offset_q      <= '0;
            mem_rdata_mem <= '0;
            misalign_o    <= 1'b0;
            bus_err_o     <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (start_bus) begin
                cyc_q    <= 1'b1;
                wb_adr_o <= ADDR_W'({mem_addr_mem[31:2], 2'b00});
                wb_dat_o <= lane_wdata;
                wb_sel_o <= lane_sel;
                wb_we_o  <= mem_write_mem;
                op_q     <= mem_op_mem;
                offset_q <= mem_addr_mem[1:0];
            end else if (misaligned_req) begin
                misalign_o    <= 1'b1;
                mem_rdata_mem <= '0;
            end else if (state == BUS) begin
                if (wb_err_i) begin
                    cyc_q         <= 1'b0;
                    bus_err_o     <= 1'b1;
                    mem_rdata_mem <= '0;
                end else if (wb_ack_i) begin
                    cyc_q <= 1'b0;
                    if (!wb_we_o)
                        mem_rdata_mem <= lane_rdata;
                end else if (timed_out) begin
                    cyc_q         <= 1'b0;
                    bus_err_o     <= 1'b1;
                    mem_rdata_mem <= BUS_FAULT_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_wb_master_bridge.sv
// Self-checking bench for core_wb_master_bridge: table of accesses driven through a
// behavioural Wishbone slave, scoreboarded load results, plus corner-case sequences.
module tb_core_wb_master_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr_mem;
    logic [31:0] mem_wdata_mem;
    logic        mem_write_mem;
    logic        mem_read_mem;
    logic [2:0]  mem_op_mem;
    logic [31:0] mem_rdata_mem;
    logic        stall_pipl;
    logic        misalign_o;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        int          waits;
        logic        err;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_stall;
    } vec_t;

    vec_t vecs[11];

    core_wb_master_bridge #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr_mem  (mem_addr_mem),
        .mem_wdata_mem (mem_wdata_mem),
        .mem_write_mem (mem_write_mem),
        .mem_read_mem  (mem_read_mem),
        .mem_op_mem    (mem_op_mem),
        .mem_rdata_mem (mem_rdata_mem),
        .stall_pipl    (stall_pipl),
        .misalign_o    (misalign_o),
        .bus_err_o     (bus_err_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_we_o       (wb_we_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] sdata, input int waits, input logic err,
                                input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_stall);
        vec_t v;
        v.rd = rd; v.wr = wr; v.op = op; v.addr = addr; v.wdata = wdata;
        v.sdata = sdata; v.waits = waits; v.err = err; v.exp_sel = exp_sel;
        v.exp_dat = exp_dat; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    // One full request: drive it, play slave, check bus signals, scoreboard the result.
    task automatic applyStimulus(input vec_t v);
        int          bus_cycles;
        int          stall_cycles;
        bit          bus_checked;
        bit          done;
        logic [31:0] exp;
        @(posedge clk); #1;
        mem_addr_mem  = v.addr;
        mem_wdata_mem = v.wdata;
        mem_op_mem    = v.op;
        mem_read_mem  = v.rd;
        mem_write_mem = v.wr;
        exp_q.push_back(v.exp_rdata);
        bus_cycles   = 0;
        stall_cycles = 0;
        bus_checked  = 0;
        done         = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (stall_pipl) stall_cycles++;
            if (wb_cyc_o) begin
                bus_cycles++;
                if (!bus_checked) begin
                    checkOutput("wb_adr", wb_adr_o, v.addr & 32'hFFFF_FFFC);
                    checkOutput("wb_sel", {28'h0, wb_sel_o}, {28'h0, v.exp_sel});
                    checkOutput("wb_we", {31'h0, wb_we_o}, {31'h0, v.wr});
                    checkOutput("wb_stb", {31'h0, wb_stb_o}, 32'h1);
                    if (v.wr) checkOutput("wb_dat", wb_dat_o, v.exp_dat);
                    bus_checked = 1;
                end
                wb_dat_i = v.sdata;
                wb_ack_i = (bus_cycles - 1 == v.waits) && !v.err;
                wb_err_i = (bus_cycles - 1 == v.waits) && v.err;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                if (bus_cycles > 0) begin
                    done = 1;
                    exp  = exp_q.pop_front();
                    checkOutput("done_rdata", mem_rdata_mem, exp);
                    checkOutput("done_stall", {31'h0, stall_pipl}, 32'h0);
                    checkOutput("done_bus_err", {31'h0, bus_err_o}, {31'h0, v.exp_err});
                    checkOutput("stall_cycles", stall_cycles, v.exp_stall);
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL access_timeout: no completion at addr 0x%08h", v.addr);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
        @(negedge clk);
        checkOutput("no_reissue_cyc", {31'h0, wb_cyc_o}, 32'h0);
        checkOutput("err_pulse_end", {31'h0, bus_err_o}, 32'h0);
    endtask

    initial begin
        reset         = 1'b1;
        mem_addr_mem  = '0;
        mem_wdata_mem = '0;
        mem_write_mem = 1'b0;
        mem_read_mem  = 1'b0;
        mem_op_mem    = 3'b010;
        wb_dat_i      = '0;
        wb_ack_i      = 1'b0;
        wb_err_i      = 1'b0;

        // rd wr op addr wdata sdata waits err sel dat rdata bus_err stall
        vecs[0]  = mk(1, 0, 3'b010, 32'h0000_1004, 32'h0,          32'h1234_5678, 2, 0, 4'hF, 32'h0,          32'h1234_5678, 0, 4);
        vecs[1]  = mk(1, 0, 3'b000, 32'h0000_1003, 32'h0,          32'h80FF_FFFF, 0, 0, 4'h8, 32'h0,          32'hFFFF_FF80, 0, 2);
        vecs[2]  = mk(1, 0, 3'b100, 32'h0000_1003, 32'h0,          32'h80FF_FFFF, 0, 0, 4'h8, 32'h0,          32'h0000_0080, 0, 2);
        vecs[3]  = mk(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,          1, 0, 4'hC, 32'hABCD_ABCD, 32'h0000_0080, 0, 3);
        vecs[4]  = mk(1, 0, 3'b001, 32'h0000_3002, 32'h0,          32'h8001_7FFF, 0, 0, 4'hC, 32'h0,          32'hFFFF_8001, 0, 2);
        vecs[5]  = mk(1, 0, 3'b101, 32'h0000_3000, 32'h0,          32'h8001_F00D, 1, 0, 4'h3, 32'h0,          32'h0000_F00D, 0, 3);
        vecs[6]  = mk(0, 1, 3'b000, 32'h0000_4001, 32'h1234_56A5, 32'h0,          1, 0, 4'h2, 32'hA5A5_A5A5, 32'h0000_F00D, 0, 3);
        vecs[7]  = mk(1, 0, 3'b000, 32'h0000_4002, 32'h0,          32'h0055_0000, 0, 0, 4'h4, 32'h0,          32'h0000_0055, 0, 2);
        vecs[8]  = mk(0, 1, 3'b010, 32'h0000_5000, 32'hDEAD_C0DE, 32'h0,          3, 0, 4'hF, 32'hDEAD_C0DE, 32'h0000_0055, 0, 5);
        vecs[9]  = mk(1, 0, 3'b011, 32'h0000_6008, 32'h0,          32'hCAFE_BABE, 0, 0, 4'hF, 32'h0,          32'hCAFE_BABE, 0, 2);
        vecs[10] = mk(1, 1, 3'b010, 32'h0000_8000, 32'h0BAD_F00D, 32'hFFFF_FFFF, 0, 0, 4'hF, 32'h0BAD_F00D, 32'hCAFE_BABE, 0, 2);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_cyc", {31'h0, wb_cyc_o}, 32'h0);
        checkOutput("reset_stb", {31'h0, wb_stb_o}, 32'h0);
        checkOutput("reset_stall", {31'h0, stall_pipl}, 32'h0);
        checkOutput("reset_rdata", mem_rdata_mem, 32'h0);
        checkOutput("reset_adr", wb_adr_o, 32'h0);
        checkOutput("reset_sel", {28'h0, wb_sel_o}, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Misaligned LW: no bus cycle, no stall, single misalign pulse, rdata cleared.
        @(posedge clk); #1;
        mem_addr_mem = 32'h0000_0006;
        mem_op_mem   = 3'b010;
        mem_read_mem = 1'b1;
        @(negedge clk);
        checkOutput("mis_stall", {31'h0, stall_pipl}, 32'h0);
        @(posedge clk); #1;
        mem_read_mem = 1'b0;
        @(negedge clk);
        checkOutput("mis_pulse", {31'h0, misalign_o}, 32'h1);
        checkOutput("mis_cyc", {31'h0, wb_cyc_o}, 32'h0);
        checkOutput("mis_rdata", mem_rdata_mem, 32'h0);
        @(negedge clk);
        checkOutput("mis_pulse_end", {31'h0, misalign_o}, 32'h0);

        // Store terminated with wb_err_i, then a normal load to reload rdata.
        applyStimulus(mk(0, 1, 3'b010, 32'h0000_7000, 32'h0000_0001, 32'h0, 1, 1, 4'hF, 32'h0000_0001, 32'h0, 1, 3));
        applyStimulus(mk(1, 0, 3'b010, 32'h0000_7004, 32'h0, 32'h1357_2468, 0, 0, 4'hF, 32'h0, 32'h1357_2468, 0, 2));

        // Reset in the middle of a bus cycle with an ack pending.
        @(posedge clk); #1;
        mem_addr_mem = 32'h0000_A000;
        mem_op_mem   = 3'b010;
        mem_read_mem = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mid_cyc_before", {31'h0, wb_cyc_o}, 32'h1);
        wb_dat_i = 32'h5555_AAAA;
        wb_ack_i = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_cyc", {31'h0, wb_cyc_o}, 32'h0);
        checkOutput("rst_mid_stb", {31'h0, wb_stb_o}, 32'h0);
        checkOutput("rst_mid_stall", {31'h0, stall_pipl}, 32'h0);
        checkOutput("rst_mid_rdata", mem_rdata_mem, 32'h0);
        checkOutput("rst_mid_adr", wb_adr_o, 32'h0);
        checkOutput("rst_mid_we", {31'h0, wb_we_o}, 32'h0);
        mem_read_mem = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wb_ack_i = 1'b0;
        checkOutput("rst_after_cyc", {31'h0, wb_cyc_o}, 32'h0);
        checkOutput("rst_after_rdata", mem_rdata_mem, 32'h0);
        checkOutput("rst_after_stall", {31'h0, stall_pipl}, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Slave never responds: abort after 8 bus cycles with the fault pattern.
        applyStimulus(mk(1, 0, 3'b010, 32'h0000_9000, 32'h0, 32'h0, 1000, 0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1, 9));
`endif

        checkOutput("scoreboard_empty", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_wb_master_bridge.md
Name: core_wb_master_bridge

Overview:
- Responder end of the core data-memory bus: accepts the core's memory-stage request (address, write data, read/write strobes, funct3 size op).
- Runs one Wishbone classic master cycle per request toward the SoC interconnect.
- Holds the core pipeline with stall_pipl until the cycle completes, then returns lane-aligned, sign- or zero-extended read data.

Parameters:
- ADDR_W, 32, address width driven on wb_adr_o.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- mem_addr_mem  in  32  byte address from the core
- mem_wdata_mem  in  32  store data, right-aligned
- mem_write_mem  in  1  store request
- mem_read_mem  in  1  load request
- mem_op_mem  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other value is treated as W
- mem_rdata_mem  out  32  extended load result
- stall_pipl  out  1  freezes the core pipeline
- misalign_o  out  1  one-cycle pulse on a misaligned access
- bus_err_o  out  1  one-cycle pulse on wb_err_i or timeout
- wb_adr_o  out  ADDR_W  word-aligned address, addr[1:0] forced to 00
- wb_dat_o  out  32  lane-replicated store data
- wb_sel_o  out  4  byte enables
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle valid
- wb_stb_o  out  1  strobe
- wb_dat_i  in  32  read data from slave
- wb_ack_i  in  1  cycle termination, success
- wb_err_i  in  1  cycle termination, error

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, including mem_rdata_mem and all wb_* outputs. Reset asserted mid-cycle drops wb_cyc_o/wb_stb_o asynchronously; any pending ack is ignored.
- Request: req = mem_read_mem | mem_write_mem. If both are set, write wins.
- stall_pipl is combinational: (IDLE & req & aligned) | BUS.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - Aligned req: register address, sel, dat, we. Go to BUS. wb_cyc_o/wb_stb_o rise next cycle.
  - Misaligned req (H/HU with addr[0]=1, or W with addr[1:0]!=0): no bus cycle, no stall. misalign_o pulses next cycle, mem_rdata_mem=0.
- BUS:
  - cyc/stb/adr/dat/sel/we are held stable.
  - On wb_ack_i: latch the extended wb_dat_i (reads only), drop cyc/stb next cycle, go to DONE.
  - On wb_err_i (err has priority if both are asserted with ack): latch rdata=0, pulse bus_err_o, go to DONE.
- DONE:
  - stall_pipl=0 and mem_rdata_mem is valid for exactly this cycle; the pipeline advances at its end.
  - Next state is always IDLE, so the still-present old request is not reissued.
  - A new request is seen in the following IDLE cycle.
- Best-case latency: request in cycle N, cyc in N+1, zero-wait ack in N+1, data and release in N+2. Stall covers cycles N and N+1.
- Byte lanes:
  - B/BU: sel = 0001 << addr[1:0]; dat = {4{wdata[7:0]}}.
  - H/HU: sel = 0011 << addr[1:0]; dat = {2{wdata[15:0]}}.
  - W: sel = 1111; dat = wdata.
- Load extension:
  - Select the byte or half-word lane by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend.
- mem_rdata_mem holds its last value between accesses. Writes do not alter it.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8..16-bit counter (sized from TIMEOUT_CYCLES) clears on entry to BUS and increments each BUS cycle.
  - Reaching TIMEOUT_CYCLES without ack/err aborts the cycle (cyc/stb low next cycle), pulses bus_err_o, sets rdata=32'hDEAD_BEEF and goes to DONE.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Shared package core_mem_pkg holds:
  - mem_op_e enum (MEM_B=3'b000, MEM_H, MEM_W, MEM_BU=3'b100, MEM_HU).
  - bridge state enum {IDLE, BUS, DONE}.
  - BUS_FAULT_DATA=32'hDEAD_BEEF.
- One sub-module, mem_lane_align (combinational): computes sel and replicated wdata from op/addr, and extracts/extends read data.

Test Plan:
- LW at 0x0000_1004, slave acks after 2 wait states with 0x1234_5678:
  - wb_adr_o=0x1004, sel=1111, stall high 4 cycles, mem_rdata_mem=0x1234_5678 in DONE.
- LB at 0x...1003, wb_dat_i=0x80FF_FFFF:
  - sel=1000, rdata=0xFFFF_FF80.
  - Same access with LBU: rdata=0x0000_0080.
- SH at 0x...2002 with wdata=0x0000_ABCD:
  - sel=1100, wb_dat_o=0xABCD_ABCD, we=1, rdata unchanged.
- LW at 0x...0006:
  - no cyc, stall never high, misalign_o pulses once, rdata=0.
- Slave returns wb_err_i on SW:
  - bus_err_o pulses once, pipeline released next cycle.
  - Then reset is asserted mid-BUS of a following LW: cyc/stb drop immediately, state IDLE, all outputs 0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks:
  - abort after 8 BUS cycles, rdata=0xDEAD_BEEF, bus_err_o pulse.
